implication_queue: RTL and testbench
====================================

Name: implication_queue

Overview:
- Downstream stage of implication_unit in the hardware BCP path.
- Consumes one per-clause implication vector per handshake and selects the implied literal slot.
- Checks the literal's variable against a per-round pending-assignment table: drops duplicates, flags conflicts.
- Buffers new implied literals in a FIFO for the assignment/propagation stage.

Parameters:
SIZE, 8, literal slots per clause; width of the implication vector
VAR_W, 6, variable index width; NUM_VARS = 2**VAR_W
DEPTH, 16, FIFO entries; power of two, at least 2

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  reset, synchronous, active-high
flush  in  1  end of BCP round: clear FIFO, pending table and conflict
imp_valid  in  1  implication vector valid
imp_ready  out  1  = !rst && !flush && state==RUN && count<DEPTH
implication  in  SIZE  implication_unit output; expected one-hot or zero
imp_lits  in  SIZE*(VAR_W+1)  slot k literal at [k*(VAR_W+1) +: VAR_W+1] = {sign, var}; sign 1 = negated
out_valid  out  1  FIFO head valid; forced 0 in CONFLICT
out_ready  in  1  consumer accepts head
out_lit  out  VAR_W+1  FIFO head literal {sign, var}
conflict  out  1  sticky conflict flag
conflict_lit  out  VAR_W+1  literal whose implication caused the conflict
multi_hot_err  out  1  one-cycle pulse when an accepted vector had more than one bit set

Behaviour:
- Reset (sync, rst high at edge): state=RUN; FIFO empty (count=0, pointers=0); pending table all invalid; conflict=0; conflict_lit=0; multi_hot_err=0; out_lit=0.
- Accept: imp_valid && imp_ready at edge N. Lowest set bit k of implication selects lit = imp_lits slot k.
  - implication==0: accepted, no effect.
  - More than one bit set: slot k is still used; multi_hot_err=1 in cycle N+1.
- Pending table, per variable {valid, sign}, for the accepted lit:
  - Invalid: set {1, sign}; push lit into FIFO.
  - Valid, same sign: duplicate; dropped, no push.
  - Valid, opposite sign: conflict=1 and conflict_lit=lit from N+1; state goes to CONFLICT; no push.
- Latency: a literal pushed at edge N into an empty FIFO gives out_valid=1 and out_lit=lit in cycle N+1. FIFO has no bypass path.
- Pop: out_valid && out_ready at an edge. Pop does not clear the pending entry; entries persist until flush/rst.
- Simultaneous push and pop with count<DEPTH: count unchanged, both pointers advance.
- Full (count==DEPTH): imp_ready=0 even if a pop occurs in the same cycle.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. count is log2(DEPTH)+1 bits.
- FSM:
  - RUN -> CONFLICT on a conflict detection.
  - CONFLICT -> RUN on flush.
  - In CONFLICT: imp_ready=0, out_valid=0, FIFO contents retained but not visible.
- Flush at edge: FIFO emptied, table cleared, conflict and conflict_lit cleared, state=RUN, all effective from the next cycle.
  - imp_ready is 0 while flush is high, so no accept coincides with a flush.
  - A pop presented during flush is ignored.
- rst has priority over flush. rst asserted mid-round discards all state exactly as reset.

Optional Feature:
- Macro: IMPQ_STATS_EN.
- Defined: adds outputs stat_pushed and stat_dups, 16 bits each.
  - Count pushes and dropped duplicates respectively.
  - Saturate at 16'hFFFF.
  - Cleared by rst only; not cleared by flush.
- Undefined: neither the ports nor the counters exist. All other behaviour is identical.

Test Plan:
- After rst: implication=8'b0000_0100, slot 2 lit={0,6'd5}, out_ready=1 -> out_valid=1 with out_lit=7'h05 one cycle after accept; popped next edge.
- Duplicate: accept {0,5}, then {0,5} again -> exactly one FIFO entry; with IMPQ_STATS_EN, stat_pushed=1 and stat_dups=1.
- Conflict: accept {0,9}, then {1,9} -> conflict=1, conflict_lit=7'h49, imp_ready=0, out_valid=0. Flush -> conflict=0, imp_ready=1 next cycle, FIFO empty.
- Full: out_ready=0, 16 distinct vars 0..15 -> imp_ready=0 at count=16. Pop with a vector offered at the same edge -> vector not accepted; 20 pops and pushes with wrap -> literals in order.
- Multi-hot: implication=8'b1001_0000 -> slot 4 literal pushed, multi_hot_err pulses exactly one cycle. implication=0 with imp_valid=1 -> accepted, no push.
- rst asserted mid-round with 3 entries and pending vars -> next cycle out_valid=0, conflict=0. Re-implying the opposite sign of an earlier var -> pushed, no conflict.

Source files
------------

// File: rtl/implication_queue.sv
// Implication queue: picks the implied literal from a per-clause vector, filters it
// through a per-round pending table and buffers new literals in a FIFO.
// Optional IMPQ_STATS_EN adds saturating push/duplicate counters.
module implication_queue #(
  parameter int SIZE  = 8,
  parameter int VAR_W = 6,
  parameter int DEPTH = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         imp_valid,
  output logic                         imp_ready,
  input  logic [SIZE-1:0]              implication,
  input  logic [SIZE*(VAR_W+1)-1:0]    imp_lits,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [VAR_W:0]               out_lit,
  output logic                         conflict,
  output logic [VAR_W:0]               conflict_lit,
  output logic                         multi_hot_err
`ifdef IMPQ_STATS_EN
  ,
  output logic [15:0]                  stat_pushed,
  output logic [15:0]                  stat_dups
`endif
);
  localparam int LIT_W    = VAR_W + 1;
  localparam int NUM_VARS = 2 ** VAR_W;
  localparam int PTR_W    = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  typedef enum logic {RUN, CONFLICT} state_e;
  state_e state_q, state_d;

  logic [LIT_W-1:0]    mem_q [DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]      count_q, count_d;
  logic [NUM_VARS-1:0] pend_vld_q, pend_sgn_q;
  logic                conflict_q, mh_q;
  logic [LIT_W-1:0]    conflict_lit_q;

  logic             hit, multi, accept, hit_acc, push, dup, conf_det, pop;
  logic [LIT_W-1:0] sel_lit;
  logic [VAR_W-1:0] lit_var;
  logic             lit_sgn;

  // Descending scan so the lowest set bit is the one that sticks.
  always_comb begin
    hit     = 1'b0;
    sel_lit = '0;
    for (int k = SIZE-1; k >= 0; k--) begin
      if (implication[k]) begin
        hit     = 1'b1;
        sel_lit = imp_lits[k*LIT_W +: LIT_W];
      end
    end
  end

  assign multi    = |(implication & (implication - SIZE'(1)));
  assign lit_var  = sel_lit[VAR_W-1:0];
  assign lit_sgn  = sel_lit[VAR_W];
  assign accept   = imp_valid && imp_ready;
  assign hit_acc  = accept && hit;
  assign push     = hit_acc && !pend_vld_q[lit_var];
  assign dup      = hit_acc && pend_vld_q[lit_var] && (pend_sgn_q[lit_var] == lit_sgn);
  assign conf_det = hit_acc && pend_vld_q[lit_var] && (pend_sgn_q[lit_var] != lit_sgn);
  assign pop      = out_valid && out_ready && !flush;
  assign count_d  = count_q + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};

  always_ff @(posedge clk) begin
    if (rst) state_q <= RUN;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:      if (conf_det) state_d = CONFLICT;
      CONFLICT: if (flush)    state_d = RUN;
      default:  state_d = RUN;
    endcase
  end

  always_comb begin
    imp_ready = !rst && !flush && (state_q == RUN) && (count_q < FULL_CNT);
    out_valid = (state_q == RUN) && (count_q != '0);
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= sel_lit;
  end

  // Pending entries outlive the pop; only a round boundary clears them.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      pend_vld_q     <= '0;
      pend_sgn_q     <= '0;
      conflict_q     <= 1'b0;
      conflict_lit_q <= '0;
    end else begin
      if (push) begin
        pend_vld_q[lit_var] <= 1'b1;
        pend_sgn_q[lit_var] <= lit_sgn;
      end
      if (conf_det) begin
        conflict_q     <= 1'b1;
        conflict_lit_q <= sel_lit;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) mh_q <= 1'b0;
    else     mh_q <= accept && multi;
  end

  assign out_lit       = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
  assign conflict      = conflict_q;
  assign conflict_lit  = conflict_lit_q;
  assign multi_hot_err = mh_q;

`ifdef IMPQ_STATS_EN
  logic [15:0] pushed_q, dups_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      pushed_q <= '0;
      dups_q   <= '0;
    end else begin
      if (push && pushed_q != 16'hFFFF) pushed_q <= pushed_q + 16'd1;
      if (dup  && dups_q   != 16'hFFFF) dups_q   <= dups_q + 16'd1;
    end
  end
  assign stat_pushed = pushed_q;
  assign stat_dups   = dups_q;
`endif
endmodule

// File: tb/tb_implication_queue.sv
// Bench for implication_queue: directed scenarios then random traffic, each cycle
// compared against a queue/table reference model.
module tb_implication_queue;
  localparam int SIZE = 8, VAR_W = 6, DEPTH = 16, LW = VAR_W + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, flush, imp_valid, imp_ready, out_valid, out_ready, conflict, multi_hot_err;
  logic [SIZE-1:0]    implication;
  logic [SIZE*LW-1:0] imp_lits;
  logic [LW-1:0]      out_lit, conflict_lit;
`ifdef IMPQ_STATS_EN
  logic [15:0] stat_pushed, stat_dups;
`endif

  implication_queue dut (
    .clk(clk), .rst(rst), .flush(flush), .imp_valid(imp_valid), .imp_ready(imp_ready),
    .implication(implication), .imp_lits(imp_lits), .out_valid(out_valid),
    .out_ready(out_ready), .out_lit(out_lit), .conflict(conflict),
    .conflict_lit(conflict_lit), .multi_hot_err(multi_hot_err)
`ifdef IMPQ_STATS_EN
    , .stat_pushed(stat_pushed), .stat_dups(stat_dups)
`endif
  );

  int checks = 0, errors = 0;

  // Reference model
  logic [LW-1:0] m_q[$];
  logic          m_pv [2**VAR_W];
  logic          m_ps [2**VAR_W];
  logic          m_conf, m_mh;
  logic [LW-1:0] m_clit;
  int            m_pushed, m_dups;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [SIZE*LW-1:0] mk(input int slot, input logic [LW-1:0] lit);
    logic [SIZE*LW-1:0] r;
    r = {$urandom, $urandom};
    r[slot*LW +: LW] = lit;
    return r;
  endfunction

  task automatic clear_round();
    m_q.delete();
    for (int v = 0; v < 2**VAR_W; v++) begin m_pv[v] = 1'b0; m_ps[v] = 1'b0; end
    m_conf = 1'b0;
    m_clit = '0;
  endtask

  task automatic cyc(input logic r, input logic f, input logic iv, input logic [SIZE-1:0] im,
                     input logic [SIZE*LW-1:0] ls, input logic ordy);
    logic exp_rdy, do_pop;
    logic [LW-1:0] lit;
    int k;
    rst = r; flush = f; imp_valid = iv; implication = im; imp_lits = ls; out_ready = ordy;
    #1;
    exp_rdy = !r && !f && !m_conf && (m_q.size() < DEPTH);
    chk("imp_ready", imp_ready, exp_rdy);
    m_mh = 1'b0;
    if (r) begin
      clear_round();
      m_pushed = 0; m_dups = 0;
    end else if (f) begin
      clear_round();
    end else begin
      do_pop = !m_conf && m_q.size() > 0 && ordy;
      if (do_pop) void'(m_q.pop_front());
      if (iv && exp_rdy) begin
        m_mh = ($countones(im) > 1);
        if (im != '0) begin
          k = 0;
          while (!im[k]) k++;
          lit = ls[k*LW +: LW];
          if (!m_pv[lit[VAR_W-1:0]]) begin
            m_pv[lit[VAR_W-1:0]] = 1'b1;
            m_ps[lit[VAR_W-1:0]] = lit[VAR_W];
            m_q.push_back(lit);
            if (m_pushed < 16'hFFFF) m_pushed++;
          end else if (m_ps[lit[VAR_W-1:0]] == lit[VAR_W]) begin
            if (m_dups < 16'hFFFF) m_dups++;
          end else begin
            m_conf = 1'b1;
            m_clit = lit;
          end
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
    chk("out_valid", out_valid, !m_conf && m_q.size() > 0);
    if (!m_conf && m_q.size() > 0) chk("out_lit", out_lit, m_q[0]);
    chk("conflict", conflict, m_conf);
    chk("conflict_lit", conflict_lit, m_clit);
    chk("multi_hot_err", multi_hot_err, m_mh);
`ifdef IMPQ_STATS_EN
    chk("stat_pushed", stat_pushed, m_pushed);
    chk("stat_dups", stat_dups, m_dups);
`endif
  endtask

  task automatic idle(input logic ordy);
    cyc(1'b0, 1'b0, 1'b0, '0, '0, ordy);
  endtask

  task automatic imp(input int slot, input logic [LW-1:0] lit, input logic ordy);
    cyc(1'b0, 1'b0, 1'b1, SIZE'(1) << slot, mk(slot, lit), ordy);
  endtask

  task automatic do_flush();
    cyc(1'b0, 1'b1, 1'b0, '0, '0, 1'b0);
  endtask

  initial begin
    logic [SIZE*LW-1:0] ls;
    logic [SIZE-1:0] im;
    int sel;
    clear_round();
    m_pushed = 0; m_dups = 0; m_mh = 1'b0;
    rst = 1'b1; flush = 1'b0; imp_valid = 1'b0; implication = '0; imp_lits = '0; out_ready = 1'b0;
    @(negedge clk);
    cyc(1'b1, 1'b0, 1'b0, '0, '0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, '0, '0, 1'b0);
    chk("rst_out_lit", out_lit, 7'h00);

    // Basic push and pop, slot 2
    imp(2, 7'h05, 1'b1);
    idle(1'b1);
    idle(1'b1);

    // Duplicate
    do_flush();
    imp(0, 7'h05, 1'b0);
    imp(3, 7'h05, 1'b0);
    idle(1'b1);
    idle(1'b1);

    // Conflict then flush
    do_flush();
    imp(1, 7'h09, 1'b0);
    imp(5, 7'h49, 1'b0);
    imp(2, 7'h0A, 1'b1);
    do_flush();
    idle(1'b1);

    // Fill, pop-while-full, wrap-around streaming, drain
    for (int i = 0; i < DEPTH; i++) imp(i % SIZE, LW'(i), 1'b0);
    imp(0, 7'd20, 1'b1);
    for (int i = 0; i < 20; i++) imp(i % SIZE, LW'(32 + i), 1'b1);
    for (int i = 0; i < DEPTH + 2; i++) idle(1'b1);

    // Multi-hot and zero vector
    do_flush();
    ls = mk(4, 7'h28);
    ls[7*LW +: LW] = 7'h29;
    cyc(1'b0, 1'b0, 1'b1, 8'b1001_0000, ls, 1'b0);
    idle(1'b0);
    cyc(1'b0, 1'b0, 1'b1, 8'b0000_0000, mk(0, 7'h11), 1'b0);
    idle(1'b1);

    // Reset mid-round discards pending vars
    do_flush();
    imp(0, 7'h01, 1'b0);
    imp(1, 7'h02, 1'b0);
    imp(2, 7'h03, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, '0, '0, 1'b0);
    imp(6, 7'h41, 1'b0);
    idle(1'b1);

    // Random traffic over a small variable range to provoke dups and conflicts
    for (int n = 0; n < 500; n++) begin
      for (int k = 0; k < SIZE; k++)
        ls[k*LW +: LW] = {1'($urandom_range(0, 1)), 6'($urandom_range(0, 9))};
      sel = $urandom_range(0, 9);
      if (sel < 6)      im = SIZE'(1) << $urandom_range(0, SIZE-1);
      else if (sel < 8) im = SIZE'($urandom);
      else              im = '0;
      sel = $urandom_range(0, 99);
      cyc(sel == 0, sel > 0 && sel < 5, 1'($urandom_range(0, 3) != 0), im, ls,
          1'($urandom_range(0, 2) != 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
